// File: rtl/block_data_memory_if.sv
// Request/response bundle for block_data_memory: level read/write requests, block data buses, busywait.
// Access counters are present only when DMEM_ACCESS_CNT_EN is defined.
interface block_data_memory_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_WIDTH  = 6,
    parameter int CNT_WIDTH   = 16
);
    localparam int BW = DATA_WIDTH * BLOCK_WORDS;

    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [BW-1:0]         writedata;
    logic [BW-1:0]         readdata;
    logic                  busywait;
`ifdef DMEM_ACCESS_CNT_EN
    logic [CNT_WIDTH-1:0]  read_count;
    logic [CNT_WIDTH-1:0]  write_count;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait, read_count, write_count
    );
    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait, read_count, write_count
    );
`else
    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );
    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
`endif
endinterface

// File: rtl/block_data_memory.sv
// Block-organised data memory with fixed counted access latency and busywait handshake.
// Optional saturating read/write completion counters under DMEM_ACCESS_CNT_EN.
module block_data_memory #(
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_WIDTH  = 6,
    parameter int LATENCY     = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic               clock,
    input  logic               reset,
    block_data_memory_if.slave dmem
);
    localparam int BW    = DATA_WIDTH * BLOCK_WORDS;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BW-1:0]         wdata_q, wdata_d;
    logic [BW-1:0]         readdata_q;
    logic [BW-1:0]         mem_q [DEPTH];
    logic                  req;
    logic                  done;

    always_comb begin
        req     = dmem.read ^ dmem.write;
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = CW'(LATENCY);
                    wr_d    = dmem.write;
                    addr_d  = dmem.address;
                    wdata_d = dmem.writedata;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    done    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gated by reset because state_q is IDLE during reset and a held request would otherwise show busy.
    assign dmem.busywait = ~reset & ((state_q == BUSY) | ((state_q == IDLE) & req));
    assign dmem.readdata = readdata_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (done && wr_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (done && !wr_q) begin
            readdata_q <= mem_q[addr_q];
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    logic [CNT_WIDTH-1:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (done) begin
            if (!wr_q && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
            if (wr_q && wr_cnt_q != '1)  wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign dmem.read_count  = rd_cnt_q;
    assign dmem.write_count = wr_cnt_q;
`endif
endmodule

// File: tb/tb_block_data_memory.sv
// Self-checking bench for block_data_memory: default geometry plus a 16x8 / LATENCY=1 / CNT_WIDTH=2 instance,
// compared against array-based reference memories.
module tb_block_data_memory;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    block_data_memory_if #(.DATA_WIDTH(8), .BLOCK_WORDS(4), .ADDR_WIDTH(6), .CNT_WIDTH(16)) a_if ();
    block_data_memory_if #(.DATA_WIDTH(16), .BLOCK_WORDS(8), .ADDR_WIDTH(6), .CNT_WIDTH(2)) b_if ();

    block_data_memory #(.DATA_WIDTH(8), .BLOCK_WORDS(4), .ADDR_WIDTH(6), .LATENCY(5), .CNT_WIDTH(16)) dut_a (
        .clock(clock), .reset(reset), .dmem(a_if.slave));
    block_data_memory #(.DATA_WIDTH(16), .BLOCK_WORDS(8), .ADDR_WIDTH(6), .LATENCY(1), .CNT_WIDTH(2)) dut_b (
        .clock(clock), .reset(reset), .dmem(b_if.slave));

    int passed = 0;
    int total  = 0;

    logic [31:0]  ma [64];
    logic [31:0]  rda;
    logic [127:0] mb [64];
    logic [127:0] rdb;
    int rdn_a, wrn_a, rdn_b, wrn_b;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        rda = '0; rdb = '0;
        rdn_a = 0; wrn_a = 0; rdn_b = 0; wrn_b = 0;
    endtask

    // One access on instance A; hold keeps the request asserted past ACK, scramble changes inputs during BUSY.
    task automatic acc_a(input bit wr, input logic [5:0] a, input logic [31:0] d, input bit hold, input bit scramble);
        int n = 0;
        @(negedge clock);
        a_if.read = !wr; a_if.write = wr; a_if.address = a; a_if.writedata = d;
        #1 chk("a_bw_rise", a_if.busywait, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!a_if.busywait) break;
            n++;
            if (scramble && i == 0) begin
                a_if.address   = a ^ 6'h3F;
                a_if.writedata = ~d;
            end
        end
        chk("a_latency", n, 5);
        if (wr) begin
            ma[a] = d;
            if (wrn_a < 65535) wrn_a++;
        end else begin
            rda = ma[a];
            if (rdn_a < 65535) rdn_a++;
        end
        chk("a_readdata", a_if.readdata, rda);
        if (!hold) begin
            a_if.read = 1'b0; a_if.write = 1'b0;
        end
    endtask

    task automatic acc_b(input bit wr, input logic [5:0] a, input logic [127:0] d);
        int n = 0;
        @(negedge clock);
        b_if.read = !wr; b_if.write = wr; b_if.address = a; b_if.writedata = d;
        #1 chk("b_bw_rise", b_if.busywait, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!b_if.busywait) break;
            n++;
        end
        chk("b_latency", n, 1);
        if (wr) begin
            mb[a] = d;
            if (wrn_b < 3) wrn_b++;
        end else begin
            rdb = mb[a];
            if (rdn_b < 3) rdn_b++;
        end
        chk("b_readdata", b_if.readdata, rdb);
        b_if.read = 1'b0; b_if.write = 1'b0;
    endtask

    initial begin
        logic [5:0]   ra;
        logic [127:0] bd;
        logic [5:0]   baddr [6];

        a_if.read = 1'b1; a_if.write = 1'b0; a_if.address = '0; a_if.writedata = '0;
        b_if.read = 1'b0; b_if.write = 1'b0; b_if.address = '0; b_if.writedata = '0;
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        #1 chk("bw_in_reset", a_if.busywait, 0);
        chk("rst_readdata", a_if.readdata, 0);
        a_if.read = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        acc_a(0, 6'h05, 32'h0, 0, 0);
        acc_a(1, 6'h2A, 32'hDEADBEEF, 0, 0);
        acc_a(0, 6'h2A, 32'h0, 0, 0);

        // read held through ACK: second access must restart from IDLE with full latency
        acc_a(0, 6'h2A, 32'h0, 1, 0);
        acc_a(0, 6'h2A, 32'h0, 0, 0);

        acc_a(1, 6'h11, 32'h12345678, 0, 1);
        acc_a(0, 6'h11, 32'h0, 0, 0);
        acc_a(0, 6'h2E, 32'h0, 0, 0);

        // illegal read&write
        acc_a(0, 6'h11, 32'h0, 0, 0);
        @(negedge clock);
        a_if.read = 1'b1; a_if.write = 1'b1; a_if.address = 6'h2A; a_if.writedata = 32'h0;
        #1 chk("illegal_bw", a_if.busywait, 0);
        repeat (3) begin
            @(negedge clock);
            chk("illegal_bw_hold", a_if.busywait, 0);
        end
        chk("illegal_readdata", a_if.readdata, rda);
        a_if.read = 1'b0; a_if.write = 1'b0;
        acc_a(0, 6'h2A, 32'h0, 0, 0);

        for (int k = 0; k < 30; k++) begin
            ra = 6'($urandom_range(0, 7));
            acc_a(1'($urandom_range(0, 1)), ra, $urandom, 0, 0);
        end
`ifdef DMEM_ACCESS_CNT_EN
        chk("a_read_count", a_if.read_count, rdn_a);
        chk("a_write_count", a_if.write_count, wrn_a);
`endif

        // reset at E0+2 of a write to 0x10 aborts it and clears memory
        acc_a(1, 6'h10, 32'hCAFEF00D, 0, 0);
        @(negedge clock);
        a_if.write = 1'b1; a_if.address = 6'h10; a_if.writedata = 32'hA5A5A5A5;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        a_if.write = 1'b0;
        model_reset();
        #1 chk("midrst_bw", a_if.busywait, 0);
        chk("midrst_readdata", a_if.readdata, 0);
`ifdef DMEM_ACCESS_CNT_EN
        chk("midrst_rcount", a_if.read_count, 0);
        chk("midrst_wcount", a_if.write_count, 0);
`endif
        @(negedge clock);
        reset = 1'b0;
        acc_a(0, 6'h10, 32'h0, 0, 0);
        acc_a(0, 6'h2A, 32'h0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            baddr[k] = 6'($urandom_range(0, 63));
            bd = {$urandom, $urandom, $urandom, $urandom};
            acc_b(1, baddr[k], bd);
        end
        for (int k = 5; k >= 0; k--) acc_b(0, baddr[k], '0);
        acc_b(0, 6'h3F ^ baddr[0], '0);
`ifdef DMEM_ACCESS_CNT_EN
        chk("b_read_count_sat", b_if.read_count, rdn_b);
        chk("b_write_count_sat", b_if.write_count, wrn_b);
        chk("a_read_count_end", a_if.read_count, rdn_a);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
